// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_e    : controller state encoding (idle, shifting, result pulse)
//   BCD_ADJ    : correction subtracted from a digit after each right shift
//   BCD_THRESH : digit value at or above which the correction applies
package bcd_to_binary_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ADJ    = 4'd3;
  localparam logic [3:0] BCD_THRESH = 4'd8;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of the reverse double-dabble.
//   digit_i : 4-bit BCD digit after the right shift
//   digit_o : digit_i - 3 when digit_i >= 8, otherwise digit_i
module bcd_digit_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // A digit >= 8 after a right shift means a 1 moved down from the next
  // decade (worth 5 here instead of 8), so take 3 back off.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_THRESH) begin
      digit_o = digit_i - BCD_ADJ;
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter, one shift per clock.
//   Clock     : system clock, rising edge
//   Reset     : asynchronous active-high reset
//   start_i   : conversion request, sampled only while idle
//   bcd_in_i  : packed BCD, digit 0 in bits [3:0]
//   bin_out_o : converted value, held until the next completion
//   done_o    : one-cycle pulse when bin_out_o/err_o update
//   busy_o    : high whenever the converter is not idle
//   err_o     : last request contained a digit > 9
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter  int unsigned DIGITS = 2,
  localparam int unsigned BIN_W  = $clog2(10 ** DIGITS)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   bcd_in_i,
  output logic [BIN_W-1:0]      bin_out_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned WorkW = BcdW + BIN_W;
  localparam int unsigned CntW  = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [WorkW-1:0]   work_q, work_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [WorkW-1:0]   work_sh;
  logic [BcdW-1:0]    shift_bcd;
  logic [BcdW-1:0]    adj_bcd;
  logic [BIN_W-1:0]   shift_acc;
  logic               bad_digit;

  // Work register is {bcd, acc}; shifting right moves the bcd LSB into acc MSB.
  assign work_sh   = {1'b0, work_q[WorkW-1:1]};
  assign shift_bcd = work_sh[WorkW-1 -: BcdW];
  assign shift_acc = work_sh[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (shift_bcd[4*g +: 4]),
      .digit_o (adj_bcd[4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in_i[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (bad_digit) begin
            // Invalid entry skips shifting and reports immediately.
            bin_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            work_d  = {bcd_in_i, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = {adj_bcd, shift_acc};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bin_d   = shift_acc;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bin_out_o = bin_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  logic       Clock;
  logic       Reset;
  logic       start;
  logic [7:0] bcd_in;
  logic [6:0] bin_out;
  logic       done;
  logic       busy;
  logic       err;

  int checks;
  int errors;

  bcd_to_binary #(.DIGITS(2)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .start_i   (start),
    .bcd_in_i  (bcd_in),
    .bin_out_o (bin_out),
    .done_o    (done),
    .busy_o    (busy),
    .err_o     (err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference: decimal value of a packed 2-digit BCD byte, and validity.
  function automatic int ref_value(input logic [7:0] b);
    int tens, ones;
    tens = int'(b) / 16;
    ones = int'(b) % 16;
    if (tens > 9 || ones > 9) return 0;
    return tens * 10 + ones;
  endfunction

  function automatic bit ref_bad(input logic [7:0] b);
    return ((int'(b) / 16) > 9) || ((int'(b) % 16) > 9);
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Presents a request, then waits for done. n = edges after the sampling
  // edge until done is seen (-1 on timeout); ts = time just after sampling.
  task automatic run_conv(input logic [7:0] b, output int n, output longint ts);
    bcd_in = b;
    start  = 1'b1;
    step();
    ts    = $time;
    start = 1'b0;
    n     = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    start  = 1'b0;
    bcd_in = 8'h00;
    repeat (3) step();
    checks++;
    if ({bin_out, done, busy, err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_held: got bin=%0d done=%b busy=%b err=%b, expected all 0",
               bin_out, done, busy, err);
    end
    Reset = 1'b0;
    repeat (2) step();
    checks++;
    if ({bin_out, done, busy, err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_released: got bin=%0d done=%b busy=%b err=%b, expected all 0",
               bin_out, done, busy, err);
    end
  endtask

  task automatic test_basic_99();
    int n;
    bcd_in = 8'h99;
    start  = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b expected 1", busy);
    end
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== 7) begin
      errors++;
      $display("FAIL latency_99: got %0d edges expected 7", n);
    end
    checks++;
    if (bin_out !== 7'd99 || err !== 1'b0) begin
      errors++;
      $display("FAIL value_99: got bin=%0d err=%b expected bin=99 err=0", bin_out, err);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width_99: got done=%b busy=%b expected 0 0", done, busy);
    end
    checks++;
    if (bin_out !== 7'd99) begin
      errors++;
      $display("FAIL hold_99: got %0d expected 99", bin_out);
    end
  endtask

  task automatic test_values();
    logic [7:0] vals [3];
    int n;
    longint ts;
    vals[0] = 8'h00;
    vals[1] = 8'h10;
    vals[2] = 8'h47;
    for (int i = 0; i < 3; i++) begin
      step();
      run_conv(vals[i], n, ts);
      checks++;
      if (n !== 7 || bin_out !== 7'(ref_value(vals[i])) || err !== 1'b0) begin
        errors++;
        $display("FAIL value_%h: got n=%0d bin=%0d err=%b expected n=7 bin=%0d err=0",
                 vals[i], n, bin_out, err, ref_value(vals[i]));
      end
    end
  endtask

  task automatic test_invalid();
    int n;
    longint ts;
    step();
    step();
    run_conv(8'h1A, n, ts);
    checks++;
    if (n !== 0 || err !== 1'b1 || bin_out !== 7'd0) begin
      errors++;
      $display("FAIL invalid_1A: got n=%0d err=%b bin=%0d expected n=0 err=1 bin=0",
               n, err, bin_out);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_after: got done=%b busy=%b err=%b expected 0 0 1", done, busy, err);
    end
    run_conv(8'h25, n, ts);
    checks++;
    if (n !== 7 || err !== 1'b0 || bin_out !== 7'd25) begin
      errors++;
      $display("FAIL recover_25: got n=%0d err=%b bin=%0d expected n=7 err=0 bin=25",
               n, err, bin_out);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [6:0] seen;
    step();
    bcd_in = 8'h63;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    // Mid-shift: new data and another start must have no effect.
    bcd_in = 8'h11;
    start  = 1'b1;
    step();
    start  = 1'b0;
    pulses = 0;
    seen   = '0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        pulses++;
        seen = bin_out;
      end
      step();
    end
    checks++;
    if (pulses !== 1 || seen !== 7'd63) begin
      errors++;
      $display("FAIL ignore_start: got pulses=%0d bin=%0d expected pulses=1 bin=63",
               pulses, seen);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queued_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int n;
    longint ts;
    bit saw_done;
    bcd_in = 8'h88;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if ({bin_out, done, busy, err} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got bin=%0d done=%b busy=%b err=%b expected all 0",
               bin_out, done, busy, err);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    Reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_conv: got activity=1 expected 0");
    end
    run_conv(8'h05, n, ts);
    checks++;
    if (n !== 7 || bin_out !== 7'd5 || err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_05: got n=%0d bin=%0d err=%b expected n=7 bin=5 err=0",
               n, bin_out, err);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    longint ts, prev_ts;
    logic [7:0] b;
    step();
    prev_ts = 0;
    for (int v = 0; v < 100; v++) begin
      b = 8'((v / 10) * 16 + (v % 10));
      run_conv(b, n, ts);
      checks++;
      if (n !== 7 || bin_out !== 7'(v) || err !== 1'b0) begin
        errors++;
        $display("FAIL sweep_%0d: got n=%0d bin=%0d err=%b expected n=7 bin=%0d err=0",
                 v, n, bin_out, err, v);
      end
      if (v > 0) begin
        checks++;
        if (ts - prev_ts !== 64'd90) begin
          errors++;
          $display("FAIL sweep_period_%0d: got %0d ns expected 90 ns", v, ts - prev_ts);
        end
      end
      prev_ts = ts;
      step();
    end
  endtask

  task automatic test_random();
    int n;
    int exp_n;
    longint ts;
    logic [7:0] b;
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom_range(0, 255));
      run_conv(b, n, ts);
      exp_n = ref_bad(b) ? 0 : 7;
      checks++;
      if (n !== exp_n || bin_out !== 7'(ref_value(b)) || err !== ref_bad(b)) begin
        errors++;
        $display("FAIL random_%h: got n=%0d bin=%0d err=%b expected n=%0d bin=%0d err=%b",
                 b, n, bin_out, err, exp_n, ref_value(b), ref_bad(b));
      end
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_99();
    test_values();
    test_invalid();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
